pc_seq_ctrl: RTL and testbench
==============================

Name: pc_seq_ctrl

Overview:
- Next-PC sequencer and fetch controller for the single-issue multi-cycle NPC core.
- Owns the write port of the PC register (write enable and write data) and issues instruction-fetch requests to the IFU memory port.
- Holds each instruction until the EXU reports completion, then selects the next PC: trap > mret > redirect > pc+4.
- Also maintains the retired-instruction counter and the halt state.

Parameters:
- XLEN, 64, PC and data width.
- RESET_VEC, 64'h8000_0000, first fetch address, written to the PC in the BOOT state.
- ILEN, 32, instruction width.

Ports:
- clock  in  1  core clock
- reset  in  1  synchronous, active-high
- pc_value  in  XLEN  current PC register output
- pc_wen  out  1  PC register write enable
- pc_wdata  out  XLEN  PC register write data
- ifu_req_valid  out  1  fetch request valid
- ifu_req_ready  in  1  memory accepts request
- ifu_req_addr  out  XLEN  fetch address
- ifu_rsp_valid  in  1  fetch response valid, single-cycle pulse
- ifu_rsp_data  in  ILEN  fetched instruction
- ifu_rsp_err  in  1  access fault, qualified by ifu_rsp_valid
- inst_valid  out  1  one-cycle pulse: inst is valid for decode
- inst  out  ILEN  registered instruction, held until the next fetch completes
- exu_done  in  1  current instruction completed
- exu_redirect  in  1  branch/jump taken, qualified by exu_done
- exu_target  in  XLEN  redirect target
- exu_trap  in  1  ecall/illegal instruction, qualified by exu_done
- exu_cause  in  XLEN  trap cause from the EXU
- exu_mret  in  1  mret, qualified by exu_done
- csr_mtvec  in  XLEN  trap vector
- csr_mepc  in  XLEN  mret return address
- trap_taken  out  1  one-cycle pulse, CSR file latches mepc/mcause
- trap_epc  out  XLEN  faulting PC
- trap_cause  out  XLEN  cause code
- halt_req  in  1  ebreak/simulation stop, qualified by exu_done
- halted  out  1  sticky halt flag
- instret  out  64  retired-instruction count

Behaviour:
- Reset is synchronous: while reset=1, state goes to BOOT and all outputs are 0, including instret and inst.
- Reset mid-fetch: any in-flight request is abandoned and a late ifu_rsp_valid is ignored; the memory side must also be reset.
- FSM states: BOOT, FREQ, FWAIT, EXEC, HALT.
- BOOT (one cycle): pc_wen=1, pc_wdata=RESET_VEC. Next state: FREQ.
- FREQ:
  - ifu_req_valid=1, ifu_req_addr=pc_value; valid and addr stay stable until ready.
  - On ifu_req_ready, go to FWAIT.
- FWAIT:
  - ifu_rsp_valid with err=0: register inst, pulse inst_valid on the next cycle, go to EXEC.
  - ifu_rsp_valid with err=1: same cycle pc_wen=1, pc_wdata=csr_mtvec, trap_taken=1, trap_epc=pc_value, trap_cause=1. Go to FREQ; instret unchanged.
- EXEC: wait for exu_done. In the exu_done cycle, pc_wen=1 and pc_wdata is chosen by priority:
  - exu_trap: csr_mtvec, with trap_taken=1, trap_epc=pc_value, trap_cause=exu_cause.
  - exu_mret: csr_mepc.
  - exu_redirect: exu_target.
  - otherwise: pc_value+4, mod 2^XLEN, wrapping with no flag.
  - Several qualifiers asserted at once: the highest priority wins; the others are ignored.
- Retirement:
  - instret increments by 1 on exu_done unless exu_trap. It wraps at 2^64.
  - Next state: FREQ, or HALT if halt_req (halt_req outranks the fetch, and the PC update still occurs).
- HALT: halted=1; no further requests or PC writes; exited only by reset.
- Latency:
  - pc_wen is combinational from state and inputs. The PC register updates at the next edge.
  - The first request after BOOT is issued one cycle later.
  - Minimum loop is 4 cycles per instruction: FREQ with ready=1, FWAIT with rsp in the same cycle, the inst_valid cycle, then EXEC with exu_done.
- exu_done outside EXEC is ignored; ifu_rsp_valid outside FWAIT is ignored.

Optional Feature:
- Macro: PC_SEQ_MISALIGN_EN.
- Defined: in the EXEC redirect case, a target with bit 1 or 0 set takes a trap instead:
  - pc_wdata=csr_mtvec, trap_taken=1, trap_cause=0, trap_epc=pc_value.
  - instret is not incremented.
- Undefined: redirect targets are written unchecked; the low bits pass through unchanged.

Decomposition:
- Package pc_seq_pkg holds:
  - state enum typedef.
  - cause constants: CAUSE_INST_MISALIGN=0, CAUSE_INST_ACCESS=1.
  - PC_STEP=4.
  - default RESET_VEC.
- Natural sub-module: pc_next_sel, a combinational priority mux that computes pc_wdata and the trap fields from the EXEC inputs, plus the misalign check.
- The FSM and counters stay in the top module.

Test Plan:
- Reset release, ready=1, rsp after 2 cycles with data 0x00000013, exu_done -> pc_wen writes 0x80000000 in BOOT, then 0x80000004; instret=1.
- exu_done with redirect=1, target=0x80001000 -> pc_wdata=0x80001000; next ifu_req_addr=0x80001000.
- exu_done with trap=1, cause=11, redirect=1, mtvec=0x80000100 -> pc_wdata=0x80000100, trap_taken pulse, trap_cause=11, instret unchanged.
- ifu_rsp_err=1 at pc 0x80000008 -> pc_wdata=mtvec, trap_cause=1, trap_epc=0x80000008, no inst_valid.
- ifu_req_ready held 0 for 5 cycles, then reset=1 for one cycle -> valid/addr stable while stalled; after reset, state BOOT and outputs 0.
- halt_req with exu_done -> halted=1 permanently, no ifu_req_valid afterwards. With PC_SEQ_MISALIGN_EN, target 0x80000002 -> trap cause 0.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the next-PC sequencer.
package pc_seq_pkg;

    typedef enum logic [2:0] {
        ST_BOOT  = 3'd0,
        ST_FREQ  = 3'd1,
        ST_FWAIT = 3'd2,
        ST_EXEC  = 3'd3,
        ST_HALT  = 3'd4
    } state_t;

    localparam logic [63:0] CAUSE_INST_MISALIGN = 64'd0;
    localparam logic [63:0] CAUSE_INST_ACCESS   = 64'd1;
    localparam logic [63:0] PC_STEP             = 64'd4;
    localparam logic [63:0] DEFAULT_RESET_VEC   = 64'h0000_0000_8000_0000;

    // A fetch target is misaligned when either of its two low bits is set.
    function automatic logic is_misaligned(input logic [1:0] lo);
        return |lo;
    endfunction

endpackage

// File: rtl/pc_seq_ctrl_pc_next_sel.sv
// Next-PC priority mux for the EXEC completion cycle: trap > mret > redirect > pc+4.
// Optional build macro PC_SEQ_MISALIGN_EN turns misaligned redirect targets into
// an instruction-address-misaligned trap.
module pc_next_sel
    import pc_seq_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] pc_value,
    input  logic            exu_trap,
    input  logic [XLEN-1:0] exu_cause,
    input  logic            exu_mret,
    input  logic            exu_redirect,
    input  logic [XLEN-1:0] exu_target,
    input  logic [XLEN-1:0] csr_mtvec,
    input  logic [XLEN-1:0] csr_mepc,
    output logic [XLEN-1:0] next_pc,
    output logic            take_trap,
    output logic [XLEN-1:0] trap_cause,
    output logic            retire
);

    // Priority select; lower-priority qualifiers are ignored once a higher one wins.
    always_comb begin
        next_pc    = pc_value + XLEN'(PC_STEP);
        take_trap  = 1'b0;
        trap_cause = '0;
        retire     = 1'b1;
        if (exu_trap) begin
            next_pc    = csr_mtvec;
            take_trap  = 1'b1;
            trap_cause = exu_cause;
            retire     = 1'b0;
        end else if (exu_mret) begin
            next_pc = csr_mepc;
        end else if (exu_redirect) begin
`ifdef PC_SEQ_MISALIGN_EN
            if (is_misaligned(exu_target[1:0])) begin
                next_pc    = csr_mtvec;
                take_trap  = 1'b1;
                trap_cause = XLEN'(CAUSE_INST_MISALIGN);
                retire     = 1'b0;
            end else begin
                next_pc = exu_target;
            end
`else
            next_pc = exu_target;
`endif
        end
    end

endmodule

// File: rtl/pc_seq_ctrl.sv
// Next-PC sequencer and fetch controller for the multi-cycle NPC core.
// Optional build macro PC_SEQ_MISALIGN_EN (handled in pc_next_sel).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_BOOT  | one cycle, writes RESET_VEC into the PC register
// ST_FREQ  | fetch request held on the IFU port until accepted
// ST_FWAIT | waiting for the fetch response (or access fault)
// ST_EXEC  | instruction handed to decode, waiting for exu_done
// ST_HALT  | sticky stop, left only through reset
module pc_seq_ctrl
    import pc_seq_pkg::*;
#(
    parameter int              XLEN      = 64,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(DEFAULT_RESET_VEC),
    parameter int              ILEN      = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [XLEN-1:0] pc_value,
    output logic            pc_wen,
    output logic [XLEN-1:0] pc_wdata,
    output logic            ifu_req_valid,
    input  logic            ifu_req_ready,
    output logic [XLEN-1:0] ifu_req_addr,
    input  logic            ifu_rsp_valid,
    input  logic [ILEN-1:0] ifu_rsp_data,
    input  logic            ifu_rsp_err,
    output logic            inst_valid,
    output logic [ILEN-1:0] inst,
    input  logic            exu_done,
    input  logic            exu_redirect,
    input  logic [XLEN-1:0] exu_target,
    input  logic            exu_trap,
    input  logic [XLEN-1:0] exu_cause,
    input  logic            exu_mret,
    input  logic [XLEN-1:0] csr_mtvec,
    input  logic [XLEN-1:0] csr_mepc,
    output logic            trap_taken,
    output logic [XLEN-1:0] trap_epc,
    output logic [XLEN-1:0] trap_cause,
    input  logic            halt_req,
    output logic            halted,
    output logic [63:0]     instret
);

    state_t          state;
    state_t          state_next;
    logic            inst_load;
    logic            exec_fire;
    logic [XLEN-1:0] sel_pc;
    logic            sel_trap;
    logic [XLEN-1:0] sel_cause;
    logic            sel_retire;

    pc_next_sel #(.XLEN(XLEN)) u_sel (
        .pc_value     (pc_value),
        .exu_trap     (exu_trap),
        .exu_cause    (exu_cause),
        .exu_mret     (exu_mret),
        .exu_redirect (exu_redirect),
        .exu_target   (exu_target),
        .csr_mtvec    (csr_mtvec),
        .csr_mepc     (csr_mepc),
        .next_pc      (sel_pc),
        .take_trap    (sel_trap),
        .trap_cause   (sel_cause),
        .retire       (sel_retire)
    );

    // Next-state and combinational outputs; everything is forced low while reset is held.
    always_comb begin
        state_next    = state;
        pc_wen        = 1'b0;
        pc_wdata      = '0;
        ifu_req_valid = 1'b0;
        ifu_req_addr  = '0;
        trap_taken    = 1'b0;
        trap_epc      = '0;
        trap_cause    = '0;
        halted        = 1'b0;
        inst_load     = 1'b0;
        exec_fire     = 1'b0;
        if (!reset) begin
            case (state)
                ST_BOOT: begin
                    pc_wen     = 1'b1;
                    pc_wdata   = RESET_VEC;
                    state_next = ST_FREQ;
                end
                ST_FREQ: begin
                    ifu_req_valid = 1'b1;
                    ifu_req_addr  = pc_value;
                    if (ifu_req_ready) state_next = ST_FWAIT;
                end
                ST_FWAIT: begin
                    if (ifu_rsp_valid) begin
                        if (ifu_rsp_err) begin
                            pc_wen     = 1'b1;
                            pc_wdata   = csr_mtvec;
                            trap_taken = 1'b1;
                            trap_epc   = pc_value;
                            trap_cause = XLEN'(CAUSE_INST_ACCESS);
                            state_next = ST_FREQ;
                        end else begin
                            inst_load  = 1'b1;
                            state_next = ST_EXEC;
                        end
                    end
                end
                ST_EXEC: begin
                    // The inst_valid cycle is the decode handoff; completion is taken from the
                    // following cycle on, which gives the four-cycle minimum loop.
                    if (exu_done && !inst_valid) begin
                        exec_fire  = 1'b1;
                        pc_wen     = 1'b1;
                        pc_wdata   = sel_pc;
                        trap_taken = sel_trap;
                        trap_epc   = sel_trap ? pc_value : '0;
                        trap_cause = sel_cause;
                        state_next = halt_req ? ST_HALT : ST_FREQ;
                    end
                end
                ST_HALT: begin
                    halted = 1'b1;
                end
                default: state_next = ST_BOOT;
            endcase
        end
    end

    // State register, instruction latch and retired-instruction counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_BOOT;
            inst_valid <= 1'b0;
            inst       <= '0;
            instret    <= '0;
        end else begin
            state      <= state_next;
            inst_valid <= inst_load;
            if (inst_load) inst <= ifu_rsp_data;
            if (exec_fire && sel_retire) instret <= instret + 64'd1;
        end
    end

endmodule

// File: tb/tb_pc_seq_ctrl.sv
module tb_pc_seq_ctrl;
    localparam logic [63:0] RV    = 64'h0000_0000_8000_0000;
    localparam logic [63:0] MTVEC = 64'h0000_0000_8000_0100;
    localparam logic [63:0] MEPC  = 64'h0000_0000_8000_0008;

    typedef struct packed {
        logic [63:0] wdata;
        logic        tt;
        logic [63:0] epc;
        logic [63:0] cause;
    } wr_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] pc_reg = 64'd0;
    logic [63:0] pc_value;
    logic        pc_wen;
    logic [63:0] pc_wdata;
    logic        ifu_req_valid;
    logic        ifu_req_ready = 1'b0;
    logic [63:0] ifu_req_addr;
    logic        ifu_rsp_valid = 1'b0;
    logic [31:0] ifu_rsp_data = 32'd0;
    logic        ifu_rsp_err = 1'b0;
    logic        inst_valid;
    logic [31:0] inst;
    logic        exu_done = 1'b0;
    logic        exu_redirect = 1'b0;
    logic [63:0] exu_target = 64'd0;
    logic        exu_trap = 1'b0;
    logic [63:0] exu_cause = 64'd0;
    logic        exu_mret = 1'b0;
    logic [63:0] csr_mtvec = MTVEC;
    logic [63:0] csr_mepc = MEPC;
    logic        trap_taken;
    logic [63:0] trap_epc;
    logic [63:0] trap_cause;
    logic        halt_req = 1'b0;
    logic        halted;
    logic [63:0] instret;

    int          compared = 0;
    int          mismatched = 0;
    logic [63:0] exp_pc = 64'd0;
    logic [63:0] exp_instret = 64'd0;
    wr_t         sb[$];

    always #5 clock = ~clock;

    // PC register model owned by the bench.
    always @(posedge clock) if (pc_wen) pc_reg <= pc_wdata;
    assign pc_value = pc_reg;

    pc_seq_ctrl dut (
        .clock(clock), .reset(reset), .pc_value(pc_value),
        .pc_wen(pc_wen), .pc_wdata(pc_wdata),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_data(ifu_rsp_data), .ifu_rsp_err(ifu_rsp_err),
        .inst_valid(inst_valid), .inst(inst),
        .exu_done(exu_done), .exu_redirect(exu_redirect), .exu_target(exu_target),
        .exu_trap(exu_trap), .exu_cause(exu_cause), .exu_mret(exu_mret),
        .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc),
        .trap_taken(trap_taken), .trap_epc(trap_epc), .trap_cause(trap_cause),
        .halt_req(halt_req), .halted(halted), .instret(instret)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [63:0] wd, input logic tt, input logic [63:0] epc,
                        input logic [63:0] cause);
        wr_t e;
        e.wdata = wd; e.tt = tt; e.epc = epc; e.cause = cause;
        sb.push_back(e);
    endtask

    // Every cycle: a PC write must occur exactly when one is expected.
    task automatic monitor();
        wr_t e;
        check("pc_wen", 64'(pc_wen), (sb.size() > 0) ? 64'd1 : 64'd0);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("pc_wdata", pc_wdata, e.wdata);
            check("trap_taken", 64'(trap_taken), 64'(e.tt));
            if (e.tt) begin
                check("trap_epc", trap_epc, e.epc);
                check("trap_cause", trap_cause, e.cause);
            end
        end
    endtask

    task automatic step();
        #1;
        monitor();
        @(negedge clock);
    endtask

    task automatic check_reset_outputs();
        check("rst_pc_wen", 64'(pc_wen), 64'd0);
        check("rst_req_valid", 64'(ifu_req_valid), 64'd0);
        check("rst_req_addr", ifu_req_addr, 64'd0);
        check("rst_inst_valid", 64'(inst_valid), 64'd0);
        check("rst_inst", 64'(inst), 64'd0);
        check("rst_instret", instret, 64'd0);
        check("rst_halted", 64'(halted), 64'd0);
        check("rst_trap_taken", 64'(trap_taken), 64'd0);
    endtask

    task automatic fetch(input logic [31:0] data, input logic err, input int stall,
                         input int rsp_delay);
        int n;
        n = 0;
        while (!ifu_req_valid && n < 20) begin
            step();
            n++;
        end
        check("req_seen", 64'(ifu_req_valid), 64'd1);
        check("req_addr", ifu_req_addr, exp_pc);
        for (int i = 0; i < stall; i++) begin
            step();
            check("stall_valid", 64'(ifu_req_valid), 64'd1);
            check("stall_addr", ifu_req_addr, exp_pc);
        end
        ifu_req_ready = 1'b1;
        step();
        ifu_req_ready = 1'b0;
        for (int i = 0; i < rsp_delay; i++) begin
            exu_done = 1'b1;  // must be ignored while fetching
            step();
            exu_done = 1'b0;
        end
        ifu_rsp_valid = 1'b1;
        ifu_rsp_data  = data;
        ifu_rsp_err   = err;
        if (err) begin
            push(MTVEC, 1'b1, exp_pc, 64'd1);
            exp_pc = MTVEC;
        end
        step();
        ifu_rsp_valid = 1'b0;
        ifu_rsp_err   = 1'b0;
        check("inst_valid", 64'(inst_valid), err ? 64'd0 : 64'd1);
        if (!err) check("inst", 64'(inst), 64'(data));
        check("instret_fetch", instret, exp_instret);
    endtask

    task automatic exec(input logic trap, input logic mret, input logic redirect,
                        input logic halt, input logic [63:0] target, input logic [63:0] cause);
        logic [63:0] nxt;
        logic        tt;
        logic [63:0] tc;
        logic        ret;
        step();
        check("inst_valid_pulse", 64'(inst_valid), 64'd0);
        tt = 1'b0; tc = 64'd0; ret = 1'b1;
        nxt = exp_pc + 64'd4;
        if (trap) begin
            nxt = MTVEC; tt = 1'b1; tc = cause; ret = 1'b0;
        end else if (mret) begin
            nxt = MEPC;
        end else if (redirect) begin
            nxt = target;
`ifdef PC_SEQ_MISALIGN_EN
            if (target[1:0] != 2'b00) begin
                nxt = MTVEC; tt = 1'b1; tc = 64'd0; ret = 1'b0;
            end
`endif
        end
        push(nxt, tt, exp_pc, tc);
        exu_done = 1'b1; exu_trap = trap; exu_mret = mret; exu_redirect = redirect;
        exu_target = target; exu_cause = cause; halt_req = halt;
        step();
        exu_done = 1'b0; exu_trap = 1'b0; exu_mret = 1'b0; exu_redirect = 1'b0;
        halt_req = 1'b0;
        exp_pc = nxt;
        if (ret) exp_instret = exp_instret + 64'd1;
        check("instret", instret, exp_instret);
        check("halted", 64'(halted), 64'(halt));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired compared=%0d", compared);
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clock);
        @(negedge clock);
        check_reset_outputs();
        reset = 1'b0;
        push(RV, 1'b0, 64'd0, 64'd0);
        exp_pc = RV;
        exp_instret = 64'd0;
        step();

        // plain instruction, response two cycles after acceptance
        fetch(32'h0000_0013, 1'b0, 0, 2);
        exec(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        // taken branch
        fetch(32'h0000_0063, 1'b0, 0, 0);
        exec(1'b0, 1'b0, 1'b1, 1'b0, 64'h8000_1000, 64'd0);
        // trap outranks redirect, instret held
        fetch(32'h0000_0073, 1'b0, 1, 0);
        exec(1'b1, 1'b0, 1'b1, 1'b0, 64'h8000_2000, 64'd11);
        // mret outranks redirect
        fetch(32'h3020_0073, 1'b0, 0, 1);
        exec(1'b0, 1'b1, 1'b1, 1'b0, 64'h8000_3000, 64'd0);
        // access fault at 0x80000008
        fetch(32'hdead_beef, 1'b1, 0, 0);
        // misaligned redirect target
        fetch(32'h0000_0067, 1'b0, 0, 0);
        exec(1'b0, 1'b0, 1'b1, 1'b0, 64'h8000_0002, 64'd0);
        // pc+4 wraps at 2^64
        fetch(32'h0000_006f, 1'b0, 0, 0);
        exec(1'b0, 1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0);
        fetch(32'h0000_0013, 1'b0, 0, 0);
        exec(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        check("wrap_pc", exp_pc, 64'd0);
        fetch(32'h0000_0013, 1'b0, 0, 0);
        exec(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);

        // request stalled five cycles, then reset mid-fetch
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", 64'(ifu_req_valid), 64'd1);
            check("hold_addr", ifu_req_addr, exp_pc);
            step();
        end
        reset = 1'b1;
        step();
        check_reset_outputs();
        reset = 1'b0;
        push(RV, 1'b0, 64'd0, 64'd0);
        exp_pc = RV;
        exp_instret = 64'd0;
        step();
        // late response from the abandoned fetch is ignored
        ifu_rsp_valid = 1'b1;
        ifu_rsp_data  = 32'h1234_5678;
        step();
        ifu_rsp_valid = 1'b0;
        check("late_rsp_inst_valid", 64'(inst_valid), 64'd0);
        check("late_rsp_inst", 64'(inst), 64'd0);

        // halt with PC update, then nothing more
        fetch(32'h0010_0073, 1'b0, 0, 0);
        exec(1'b0, 1'b0, 1'b0, 1'b1, 64'd0, 64'd0);
        for (int i = 0; i < 5; i++) begin
            exu_done = 1'b1;
            ifu_req_ready = 1'b1;
            step();
            check("halt_req_valid", 64'(ifu_req_valid), 64'd0);
            check("halt_sticky", 64'(halted), 64'd1);
            check("halt_instret", instret, exp_instret);
        end
        exu_done = 1'b0;
        ifu_req_ready = 1'b0;
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
